// File: rtl/quality_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// Module      : quality_ctrl_pkg
// Description : Shared states, default thresholds and code values for the
//               quality compression controller.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package quality_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam logic [7:0] c_DEF_T0 = 8'd0;
    localparam logic [7:0] c_DEF_T1 = 8'd20;
    localparam logic [7:0] c_DEF_T2 = 8'd30;
    localparam logic [7:0] c_DEF_T3 = 8'd40;

    localparam logic [1:0] c_Q00 = 2'b00;
    localparam logic [1:0] c_Q01 = 2'b01;
    localparam logic [1:0] c_Q10 = 2'b10;
    localparam logic [1:0] c_Q11 = 2'b11;

endpackage

`default_nettype wire

// File: rtl/quality_compress_ctrl_score.sv
// ---------------------------------------------------------------------------
// Module      : compressQualityScore
// Description : Combinational mapping of LENGTH 8-bit quality scores to
//               2-bit codes against four thresholds.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module compressQualityScore
    import quality_ctrl_pkg::*;
#(
    parameter int LENGTH = 8
) (
    input  logic [LENGTH*8-1:0] scores,
    input  logic [7:0]          t0,
    input  logic [7:0]          t1,
    input  logic [7:0]          t2,
    input  logic [7:0]          t3,
    output logic [LENGTH*2-1:0] codes
);

    for (genvar i = 0; i < LENGTH; i++) begin : g_char
        logic [7:0] w_score;
        logic [1:0] w_code;

        assign w_score = scores[8*i +: 8];

        // First matching range wins; anything unmatched (including s<t0) is 11.
        always_comb begin
            w_code = c_Q11;
            if (w_score >= t0 && w_score < t1) begin
                w_code = c_Q00;
            end else if (w_score >= t1 && w_score < t2) begin
                w_code = c_Q01;
            end else if (w_score >= t2 && w_score < t3) begin
                w_code = c_Q10;
            end
        end

        assign codes[2*i +: 2] = w_code;
    end

endmodule

`default_nettype wire

// File: rtl/quality_compress_ctrl.sv
// ---------------------------------------------------------------------------
// Module      : quality_compress_ctrl
// Description : Owns the quality thresholds, compresses streamed score beats
//               and packs them into one record per read.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module quality_compress_ctrl
    import quality_ctrl_pkg::*;
#(
    parameter int BEAT    = 8,
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = $clog2(BEAT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfgWrEn,
    input  logic [1:0]           cfgAddr,
    input  logic [7:0]           cfgData,
    output logic                 cfgErr,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [BEAT*8-1:0]    inData,
    input  logic                 inLast,
    input  logic [CNT_W-1:0]     inCount,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [MAX_LEN*2-1:0] outQuality,
    output logic [LEN_W-1:0]     outLength,
    output logic                 outOverflow,
    output logic                 busy
);

    localparam int SUM_W = LEN_W + 1;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [7:0]             r_t0, r_t1, r_t2, r_t3;
    logic [MAX_LEN*2-1:0]   r_buf;
    logic [LEN_W-1:0]       r_cnt;
    logic                   r_ovf;
    logic                   r_cfgErr;

    logic                   w_acc;
    logic                   w_cfgOk;
    logic                   w_first;
    logic [BEAT*2-1:0]      w_codes;
    logic [BEAT*2-1:0]      w_mask;
    logic [SUM_W-1:0]       w_base;
    logic [SUM_W-1:0]       w_chars;
    logic [SUM_W-1:0]       w_sum;
    logic [SUM_W-1:0]       w_newLen;
    logic [SUM_W-1:0]       w_stored;
    logic                   w_ovfNow;
    logic [MAX_LEN*2-1:0]   w_wide;
    logic [MAX_LEN*2-1:0]   w_nextBuf;

    compressQualityScore #(
        .LENGTH (BEAT)
    ) u_score (
        .scores (inData),
        .t0     (r_t0),
        .t1     (r_t1),
        .t2     (r_t2),
        .t3     (r_t3),
        .codes  (w_codes)
    );

    assign inReady     = (r_state != EMIT);
    assign outValid    = (r_state == EMIT);
    assign busy        = (r_state != IDLE);
    assign outQuality  = r_buf;
    assign outLength   = r_cnt;
    assign outOverflow = r_ovf;
    assign cfgErr      = r_cfgErr;

    assign w_acc   = inValid && inReady;
    assign w_first = (r_state == IDLE);
    assign w_cfgOk = cfgWrEn && (r_state == IDLE) && !w_acc;

    // Offset and stored-char count for this beat, saturating at MAX_LEN.
    always_comb begin
        w_base = w_first ? '0 : SUM_W'(r_cnt);
        if (!inLast || inCount > CNT_W'(BEAT)) begin
            w_chars = SUM_W'(BEAT);
        end else begin
            w_chars = SUM_W'(inCount);
        end
        w_sum    = w_base + w_chars;
        w_ovfNow = (w_sum > SUM_W'(MAX_LEN));
        w_newLen = w_ovfNow ? SUM_W'(MAX_LEN) : w_sum;
        w_stored = w_newLen - w_base;
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < BEAT; i++) begin
            if (SUM_W'(i) < w_stored) begin
                w_mask[2*i +: 2] = 2'b11;
            end
        end
        w_wide                = '0;
        w_wide[BEAT*2-1:0]    = w_codes & w_mask;
        // The first beat of a read starts from a cleared buffer.
        w_nextBuf = (w_first ? '0 : r_buf) | (w_wide << {w_base, 1'b0});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_acc) w_nextState = inLast ? EMIT : ACCUM;
            ACCUM:   if (w_acc && inLast) w_nextState = EMIT;
            EMIT:    if (outReady) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf    <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_cfgErr <= 1'b0;
            r_t0     <= c_DEF_T0;
            r_t1     <= c_DEF_T1;
            r_t2     <= c_DEF_T2;
            r_t3     <= c_DEF_T3;
        end else begin
            r_cfgErr <= cfgWrEn && !w_cfgOk;
            if (w_cfgOk) begin
                case (cfgAddr)
                    2'd0:    r_t0 <= cfgData;
                    2'd1:    r_t1 <= cfgData;
                    2'd2:    r_t2 <= cfgData;
                    default: r_t3 <= cfgData;
                endcase
            end
            if (w_acc) begin
                r_buf <= w_nextBuf;
                r_cnt <= LEN_W'(w_newLen);
                r_ovf <= (w_first ? 1'b0 : r_ovf) | w_ovfNow;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_quality_compress_ctrl.sv
// ---------------------------------------------------------------------------
// Module      : tb_quality_compress_ctrl
// Description : Randomized and directed bench for quality_compress_ctrl with a
//               read-level reference model.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_quality_compress_ctrl;

    localparam int BEAT    = 8;
    localparam int MAX_LEN = 64;
    localparam int LEN_W   = 7;
    localparam int CNT_W   = 4;

    logic                 clk;
    logic                 rst;
    logic                 cfgWrEn;
    logic [1:0]           cfgAddr;
    logic [7:0]           cfgData;
    logic                 cfgErr;
    logic                 inValid;
    logic                 inReady;
    logic [BEAT*8-1:0]    inData;
    logic                 inLast;
    logic [CNT_W-1:0]     inCount;
    logic                 outValid;
    logic                 outReady;
    logic [MAX_LEN*2-1:0] outQuality;
    logic [LEN_W-1:0]     outLength;
    logic                 outOverflow;
    logic                 busy;

    int checks   = 0;
    int failures = 0;
    int readyMode = 0;

    quality_compress_ctrl #(
        .BEAT    (BEAT),
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfgWrEn     (cfgWrEn),
        .cfgAddr     (cfgAddr),
        .cfgData     (cfgData),
        .cfgErr      (cfgErr),
        .inValid     (inValid),
        .inReady     (inReady),
        .inData      (inData),
        .inLast      (inLast),
        .inCount     (inCount),
        .outValid    (outValid),
        .outReady    (outReady),
        .outQuality  (outQuality),
        .outLength   (outLength),
        .outOverflow (outOverflow),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (read level) ----------------
    typedef struct {
        logic [127:0] q;
        int           len;
        bit           ovf;
    } rec_t;

    int          thr[4];
    logic [1:0]  curCodes[$];
    rec_t        expQ[$];
    bit          inRead;
    bit          expCfgErr;

    function automatic logic [1:0] codeOf(input int s);
        if (s >= thr[0] && s < thr[1]) return 2'b00;
        if (s >= thr[1] && s < thr[2]) return 2'b01;
        if (s >= thr[2] && s < thr[3]) return 2'b10;
        return 2'b11;
    endfunction

    task automatic modelReset();
        thr[0] = 0; thr[1] = 20; thr[2] = 30; thr[3] = 40;
        curCodes.delete();
        expQ.delete();
        inRead    = 0;
        expCfgErr = 0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            modelReset();
            chk("rst_outValid", 128'(outValid), 128'(0));
            chk("rst_inReady", 128'(inReady), 128'(1));
            chk("rst_busy", 128'(busy), 128'(0));
            chk("rst_cfgErr", 128'(cfgErr), 128'(0));
            chk("rst_outLength", 128'(outLength), 128'(0));
            chk("rst_outOverflow", 128'(outOverflow), 128'(0));
            chk("rst_outQuality", outQuality, 128'(0));
        end else begin
            bit acc;
            int n;
            chk("outValid", 128'(outValid), 128'(expQ.size() != 0));
            chk("inReady", 128'(inReady), 128'(expQ.size() == 0));
            chk("busy", 128'(busy), 128'(inRead || expQ.size() != 0));
            chk("cfgErr", 128'(cfgErr), 128'(expCfgErr));
            if (expQ.size() != 0) begin
                chk("outQuality", outQuality, expQ[0].q);
                chk("outLength", 128'(outLength), 128'(expQ[0].len));
                chk("outOverflow", 128'(outOverflow), 128'(expQ[0].ovf));
            end
            acc = inValid && (expQ.size() == 0);
            expCfgErr = cfgWrEn && !(!inRead && expQ.size() == 0 && !acc);
            if (cfgWrEn && !expCfgErr) thr[cfgAddr] = int'(cfgData);
            if (expQ.size() != 0 && outReady) void'(expQ.pop_front());
            if (acc) begin
                n = inLast ? ((int'(inCount) > BEAT) ? BEAT : int'(inCount)) : BEAT;
                for (int i = 0; i < n; i++) curCodes.push_back(codeOf(int'(inData[8*i +: 8])));
                if (inLast) begin
                    rec_t r;
                    r.len = (curCodes.size() > MAX_LEN) ? MAX_LEN : curCodes.size();
                    r.ovf = (curCodes.size() > MAX_LEN);
                    r.q   = '0;
                    for (int j = 0; j < r.len; j++) r.q[2*j +: 2] = curCodes[j];
                    expQ.push_back(r);
                    curCodes.delete();
                    inRead = 0;
                end else begin
                    inRead = 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        outReady = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       outReady = ($urandom_range(0, 2) != 0);
                1:       outReady = 1'b0;
                default: outReady = 1'b1;
            endcase
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] randBeat();
        logic [63:0] d;
        for (int i = 0; i < BEAT; i++) d[8*i +: 8] = 8'($urandom_range(0, 60));
        return d;
    endfunction

    // Present a beat until accepted; cfgWrEn is only held for the first cycle.
    task automatic sendBeat(input logic [63:0] d, input bit last, input logic [3:0] cnt);
        bit ready;
        int waited;
        inValid = 1'b1; inData = d; inLast = last; inCount = cnt;
        waited = 0;
        do begin
            @(negedge clk);
            ready = inReady;
            @(posedge clk);
            #1;
            cfgWrEn = 1'b0;
            waited++;
        end while (!ready && waited < 200);
        if (!ready) begin
            failures++;
            $display("FAIL beat_accept_timeout waited=%0d required=accept", waited);
        end
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    task automatic waitIdle();
        int waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (busy && waited < 300);
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL idle_timeout busy=%0b required=0", busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfgWrite(input logic [1:0] a, input logic [7:0] v);
        cfgWrEn = 1'b1; cfgAddr = a; cfgData = v;
        @(posedge clk);
        #1;
        cfgWrEn = 1'b0;
    endtask

    task automatic sendRead(input int n);
        int nb, lastCnt;
        logic [3:0] c;
        if (n == 0) begin
            sendBeat(randBeat(), 1'b1, 4'd0);
            return;
        end
        nb = (n + BEAT - 1) / BEAT;
        lastCnt = n - (nb - 1) * BEAT;
        for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 5) == 0) begin
                cfgWrEn = 1'b1;
                cfgAddr = 2'($urandom_range(0, 3));
                cfgData = 8'($urandom_range(0, 63));
            end
            if (b == nb - 1) begin
                c = 4'(lastCnt);
                if (lastCnt == BEAT && $urandom_range(0, 1) == 1) c = 4'($urandom_range(9, 15));
                sendBeat(randBeat(), 1'b1, c);
            end else begin
                sendBeat(randBeat(), 1'b0, 4'd0);
            end
        end
    endtask

    initial begin
        logic [127:0] held;
        rst = 1'b1; cfgWrEn = 1'b0; cfgAddr = '0; cfgData = '0;
        inValid = 1'b0; inData = '0; inLast = 1'b0; inCount = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Defaults, one last beat of four chars
        sendBeat({32'hFFFF_FFFF, 8'd45, 8'd35, 8'd25, 8'd5}, 1'b1, 4'd4);
        @(negedge clk);
        chk("t1_valid_latency", 128'(outValid), 128'(1));
        chk("t1_quality", outQuality, 128'hE4);
        chk("t1_length", 128'(outLength), 128'(4));
        chk("t1_overflow", 128'(outOverflow), 128'(0));
        waitIdle();

        // Threshold write in IDLE, rejected write in ACCUM
        cfgWrite(2'd1, 8'd10);
        sendBeat({56'h0, 8'd15}, 1'b1, 4'd1);
        @(negedge clk);
        chk("t2_code01", outQuality, 128'h1);
        waitIdle();
        sendBeat({8{8'd50}}, 1'b0, 4'd0);
        cfgWrite(2'd1, 8'd50);
        @(negedge clk);
        chk("t2_cfgErr", 128'(cfgErr), 128'(1));
        @(posedge clk);
        #1;
        sendBeat({56'h0, 8'd15}, 1'b1, 4'd1);
        @(negedge clk);
        chk("t2_kept_t1", 128'(outQuality[17:16]), 128'(1));
        chk("t2_length", 128'(outLength), 128'(9));
        waitIdle();

        // 29-character read
        sendRead(29);
        @(negedge clk);
        chk("t3_length", 128'(outLength), 128'(29));
        chk("t3_upper_zero", 128'(outQuality[127:58]), 128'(0));
        waitIdle();

        // Overflow: ten full beats
        for (int b = 0; b < 10; b++) sendBeat(randBeat(), (b == 9), 4'd8);
        @(negedge clk);
        chk("t4_length", 128'(outLength), 128'(64));
        chk("t4_overflow", 128'(outOverflow), 128'(1));
        waitIdle();

        // Backpressure in EMIT
        readyMode = 1;
        @(posedge clk);
        #1;
        sendRead(8);
        @(negedge clk);
        held = outQuality;
        for (int k = 0; k < 5; k++) begin
            chk("t5_valid_held", 128'(outValid), 128'(1));
            chk("t5_inReady_low", 128'(inReady), 128'(0));
            chk("t5_stable", outQuality, held);
            @(negedge clk);
        end
        readyMode = 2;
        waitIdle();
        sendRead(3);
        readyMode = 0;
        waitIdle();

        // Randomized reads with interleaved config writes
        for (int r = 0; r < 40; r++) begin
            int n;
            case ($urandom_range(0, 5))
                0:       n = 0;
                1:       n = $urandom_range(65, 90);
                default: n = $urandom_range(1, 64);
            endcase
            sendRead(n);
            if ($urandom_range(0, 2) == 0) cfgWrite(2'($urandom_range(0, 3)), 8'($urandom_range(0, 63)));
            if (n != 0 && n % BEAT == 0 && $urandom_range(0, 3) == 0) begin
                sendRead(BEAT);
                sendBeat(randBeat(), 1'b1, 4'd0);
            end
        end
        waitIdle();

        // Reset in the middle of a read
        cfgWrite(2'd1, 8'd10);
        sendBeat({8{8'd50}}, 1'b0, 4'd0);
        sendBeat({8{8'd50}}, 1'b0, 4'd0);
        rst = 1'b1;
        #1;
        chk("t6_async_inReady", 128'(inReady), 128'(1));
        chk("t6_async_busy", 128'(busy), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        sendBeat({40'h0, 8'd15, 8'd5, 8'd45}, 1'b1, 4'd3);
        @(negedge clk);
        chk("t6_no_residue", outQuality, 128'h03);
        chk("t6_length", 128'(outLength), 128'(3));
        waitIdle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/quality_compress_ctrl.md
Name: quality_compress_ctrl

Overview:
Streaming controller that owns the four quality thresholds and sequences the per-character quality compressor over variable-length reads. Raw 8-bit quality scores arrive in fixed-width beats with a last flag. The block compresses each beat to 2-bit codes and packs them into a per-read record. It emits one record per read over a valid/ready interface. It sits between the read-ingest FIFO and the k-mer/correction pipeline.

Parameters:
BEAT, 8, quality characters per input beat.
MAX_LEN, 64, maximum read length in characters; must be a multiple of BEAT.
LEN_W, $clog2(MAX_LEN+1), width of the length fields.
CNT_W, $clog2(BEAT+1), width of inCount.

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
cfgWrEn  input  1  threshold write strobe
cfgAddr  input  2  threshold index 0..3
cfgData  input  8  threshold value
cfgErr  output  1  one-cycle pulse: write rejected
inValid  input  1  input beat valid
inReady  output  1  input beat accepted when inValid and inReady are both high
inData  input  BEAT*8  scores; char i occupies bits [8i+7:8i]
inLast  input  1  final beat of the read
inCount  input  CNT_W  valid chars in the last beat (0..BEAT); ignored on non-last beats
outValid  output  1  record valid
outReady  input  1  record consumed
outQuality  output  MAX_LEN*2  packed codes; char j occupies bits [2j+1:2j]
outLength  output  LEN_W  characters stored in the record
outOverflow  output  1  read exceeded MAX_LEN; excess characters dropped
busy  output  1  high in ACCUM or EMIT

Behaviour:
- Reset (async, immediate) values:
  - state IDLE; all outputs 0 except inReady=1.
  - thresholds t0..t3 = 0, 20, 30, 40.
  - record buffer, length counter and overflow flag cleared.
- Reset in mid-read discards the partial read; no record is emitted.
- Code per character, using score s:
  - t0<=s<t1 -> 00
  - t1<=s<t2 -> 01
  - t2<=s<t3 -> 10
  - otherwise -> 11. This includes s<t0.
  - Non-monotonic thresholds are not checked; the first matching range wins.
- States:
  - IDLE: inReady=1. An accepted beat writes its codes at offset 0. The next state is ACCUM, or EMIT if inLast is set.
  - ACCUM: inReady=1. Each accepted beat writes its codes at offset cnt*2, then cnt += chars. Moves to EMIT on an accepted last beat.
  - EMIT: inReady=0, outValid=1, record held stable. On outValid and outReady both high, the next state is IDLE. outValid drops the following cycle.
- Chars per beat: BEAT on non-last beats, inCount on the last beat. inCount>BEAT is clamped to BEAT.
- Unused positions: buffer positions beyond the final length read as 00. The buffer is zeroed when the first beat of each read is accepted, merged with that beat's write.
- Overflow: if cnt+chars>MAX_LEN, only chars up to MAX_LEN are stored, outLength saturates at MAX_LEN, and outOverflow=1. The remaining beats of the read are still consumed until inLast.
- Empty read: a last beat with inCount=0 in IDLE emits outLength=0 and outQuality all zero.
- Latency: a last beat accepted in cycle N gives outValid=1 in cycle N+1. Minimum one idle cycle between reads (the EMIT cycle).
- Config writes:
  - Accepted only in IDLE with no beat accepted in the same cycle; the new value is used from the next cycle.
  - Otherwise the write is ignored and cfgErr pulses high for one cycle.
  - Thresholds cannot change within a read.
- outQuality, outLength and outOverflow are registered. They are stable throughout EMIT.

Decomposition:
- Package quality_ctrl_pkg holds:
  - state enum {IDLE, ACCUM, EMIT};
  - default threshold constants (0, 20, 30, 40);
  - code constants Q00..Q11.
- One sub-module: instantiate the existing compressQualityScore with LENGTH=BEAT on inData. This is the purely combinational datapath.
- The controller holds the FSM, threshold registers, counter, masking/packing shifter and output registers.

Test Plan:
1. Defaults, one last beat, inCount=4, scores {5,25,35,45} -> codes 00,01,10,11 packed as 0xE4 in the low bits. outLength=4, outOverflow=0, outValid in cycle N+1.
2. Write t1=10 in IDLE, then a last beat with score 15 -> code 01. A write attempted in ACCUM -> cfgErr pulse, old value kept.
3. Read of 3 full beats plus a last beat with inCount=5 (BEAT=8) -> outLength=29, chars at offsets 0..28, bits above 57 zero.
4. 10 full beats with MAX_LEN=64 -> outLength=64, outOverflow=1, beats 9-10 consumed with inReady high.
5. Hold outReady=0 for 5 cycles in EMIT -> record stable, inReady=0. Release -> IDLE, next read accepted the cycle after.
6. Assert rst mid-ACCUM -> immediate IDLE with defaults restored. A new 1-beat read afterwards produces a correct record with no residue from the aborted read.
